spi_mux_queue: RTL and testbench

SPI_MUX_QUEUE -- requirements
Module: spi_mux_queue

---
 rtl/spi_queue_pkg.sv | 29 ++
 rtl/spi_chan_fifo.sv | 72 +++++++
 rtl/spi_mux_queue.sv | 132 +++++++++++++
 tb/tb_spi_mux_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_queue_pkg
//  Description : Shared width helpers and per-channel status type for the
//                SPI multiplexed queue block.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_queue_pkg;

    // Pointer width for a FIFO of the given depth (never below one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Channel-select width for the given channel count (never below one bit).
    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Master-visible status of one channel.
    typedef struct packed {
        logic tx_space;
        logic rx_avail;
        logic ovf_err;
        logic udf_err;
    } chan_status_t;

endpackage
`default_nettype wire

// File: rtl/spi_chan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_chan_fifo
//  Description : Single val/rdy FIFO with occupancy count. Acceptance is
//                decided from the registered count only, so a full FIFO
//                refuses a write even when a read fires in the same cycle.
//                The head word reads as zero while the FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_chan_fifo
    import spi_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_val,
    output logic                     enq_rdy,
    input  logic [WIDTH-1:0]         enq_msg,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [WIDTH-1:0]         deq_msg,
    output logic [addr_w(DEPTH):0]   count
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam logic [ADDR_W:0] c_full = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic w_enq;
    logic w_deq;

    assign enq_rdy = (r_count != c_full);
    assign deq_val = (r_count != '0);
    assign w_enq   = enq_val & enq_rdy;
    assign w_deq   = deq_rdy & deq_val;
    assign deq_msg = deq_val ? r_mem[r_rd_ptr] : '0;
    assign count   = r_count;

    // Pointer, count and storage update; depth is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= enq_msg;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_mux_queue.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mux_queue
//  Description : Multi-channel SPI queue. Each channel owns a to-device and a
//                from-device FIFO; a single master port addresses one channel
//                at a time via ch_sel. Dropped writes and empty reads are
//                recorded in sticky per-channel error bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_mux_queue
    import spi_queue_pkg::*;
#(
    parameter int PACK_SIZE   = 32,
    parameter int NUM_ENTRIES = 4,
    parameter int NCH         = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     serve,
    input  logic                     seize,
    input  logic                     hard_msg,
    input  logic [ch_w(NCH)-1:0]     ch_sel,
    input  logic [PACK_SIZE-1:0]     from_master,
    output logic [PACK_SIZE-1:0]     to_master,
    output logic [NCH-1:0]           send_val,
    input  logic [NCH-1:0]           send_rdy,
    output logic [NCH*PACK_SIZE-1:0] send_msg,
    input  logic [NCH-1:0]           recv_val,
    output logic [NCH-1:0]           recv_rdy,
    input  logic [NCH*PACK_SIZE-1:0] recv_msg,
    output logic [NCH-1:0]           tx_space,
    output logic [NCH-1:0]           rx_avail,
    output logic [NCH-1:0]           ovf_err,
    output logic [NCH-1:0]           udf_err,
    input  logic                     clr_err
);

    localparam int CH_W   = ch_w(NCH);
    localparam int ADDR_W = addr_w(NUM_ENTRIES);
    localparam logic [ADDR_W:0] c_full = (ADDR_W + 1)'(NUM_ENTRIES);

    logic [NCH-1:0]       w_sel;
    logic [NCH-1:0]       w_tx_enq;
    logic [NCH-1:0]       w_rx_deq;
    logic [NCH-1:0]       w_tx_space;
    logic [NCH-1:0]       w_rx_avail;
    logic [NCH-1:0]       w_ovf_set;
    logic [NCH-1:0]       w_udf_set;
    logic [ADDR_W:0]      w_tx_count [NCH];
    logic [ADDR_W:0]      w_rx_count [NCH];
    logic [PACK_SIZE-1:0] w_rx_head  [NCH];
    chan_status_t         w_status   [NCH];
    logic [PACK_SIZE-1:0] w_to_master;
    logic [NCH-1:0]       r_ovf_err;
    logic [NCH-1:0]       r_udf_err;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            // An out-of-range ch_sel matches no channel, so it is ignored.
            assign w_sel[c]     = (ch_sel == CH_W'(c));
            assign w_tx_enq[c]  = serve & ~hard_msg & w_sel[c];
            assign w_rx_deq[c]  = seize & w_sel[c];
            assign w_ovf_set[c] = w_tx_enq[c] & (w_tx_count[c] == c_full);
            assign w_udf_set[c] = w_rx_deq[c] & (w_rx_count[c] == '0);

            spi_chan_fifo #(
                .WIDTH (PACK_SIZE),
                .DEPTH (NUM_ENTRIES)
            ) u_tx_fifo (
                .clk     (clk),
                .reset   (reset),
                .enq_val (w_tx_enq[c]),
                .enq_rdy (w_tx_space[c]),
                .enq_msg (from_master),
                .deq_val (send_val[c]),
                .deq_rdy (send_rdy[c]),
                .deq_msg (send_msg[c*PACK_SIZE +: PACK_SIZE]),
                .count   (w_tx_count[c])
            );

            spi_chan_fifo #(
                .WIDTH (PACK_SIZE),
                .DEPTH (NUM_ENTRIES)
            ) u_rx_fifo (
                .clk     (clk),
                .reset   (reset),
                .enq_val (recv_val[c]),
                .enq_rdy (recv_rdy[c]),
                .enq_msg (recv_msg[c*PACK_SIZE +: PACK_SIZE]),
                .deq_val (w_rx_avail[c]),
                .deq_rdy (w_rx_deq[c]),
                .deq_msg (w_rx_head[c]),
                .count   (w_rx_count[c])
            );

            assign w_status[c] = '{tx_space: w_tx_space[c], rx_avail: w_rx_avail[c],
                                   ovf_err:  r_ovf_err[c],  udf_err:  r_udf_err[c]};
            assign tx_space[c] = w_status[c].tx_space;
            assign rx_avail[c] = w_status[c].rx_avail;
            assign ovf_err[c]  = w_status[c].ovf_err;
            assign udf_err[c]  = w_status[c].udf_err;
        end
    endgenerate

    // Read-data mux; the FIFO head is already zero when that FIFO is empty.
    always_comb begin
        w_to_master = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_sel[c]) begin
                w_to_master = w_rx_head[c];
            end
        end
    end

    assign to_master = w_to_master;

    // Sticky error bits; a clear keeps only errors raised in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_err <= '0;
            r_udf_err <= '0;
        end else if (clr_err) begin
            r_ovf_err <= w_ovf_set;
            r_udf_err <= w_udf_set;
        end else begin
            r_ovf_err <= r_ovf_err | w_ovf_set;
            r_udf_err <= r_udf_err | w_udf_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_mux_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_mux_queue
//  Description : Directed self-checking bench for spi_mux_queue (NCH=2,
//                PACK_SIZE=32, NUM_ENTRIES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mux_queue;

    localparam int PS  = 32;
    localparam int NCH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          serve;
    logic          seize;
    logic          hard_msg;
    logic [0:0]    ch_sel;
    logic [PS-1:0] from_master;
    logic [PS-1:0] to_master;
    logic [NCH-1:0]    send_val;
    logic [NCH-1:0]    send_rdy;
    logic [NCH*PS-1:0] send_msg;
    logic [NCH-1:0]    recv_val;
    logic [NCH-1:0]    recv_rdy;
    logic [NCH*PS-1:0] recv_msg;
    logic [NCH-1:0]    tx_space;
    logic [NCH-1:0]    rx_avail;
    logic [NCH-1:0]    ovf_err;
    logic [NCH-1:0]    udf_err;
    logic              clr_err;

    int checks = 0;
    int errors = 0;

    spi_mux_queue #(
        .PACK_SIZE   (PS),
        .NUM_ENTRIES (4),
        .NCH         (NCH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serve       (serve),
        .seize       (seize),
        .hard_msg    (hard_msg),
        .ch_sel      (ch_sel),
        .from_master (from_master),
        .to_master   (to_master),
        .send_val    (send_val),
        .send_rdy    (send_rdy),
        .send_msg    (send_msg),
        .recv_val    (recv_val),
        .recv_rdy    (recv_rdy),
        .recv_msg    (recv_msg),
        .tx_space    (tx_space),
        .rx_avail    (rx_avail),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " send_val"},  64'(send_val),  64'h0);
        chk({tag, " recv_rdy"},  64'(recv_rdy),  64'h3);
        chk({tag, " tx_space"},  64'(tx_space),  64'h3);
        chk({tag, " rx_avail"},  64'(rx_avail),  64'h0);
        chk({tag, " ovf_err"},   64'(ovf_err),   64'h0);
        chk({tag, " udf_err"},   64'(udf_err),   64'h0);
        chk({tag, " to_master"}, 64'(to_master), 64'h0);
        chk({tag, " send_msg"},  send_msg,       64'h0);
    endtask

    initial begin
        reset = 1'b1; serve = 1'b0; seize = 1'b0; hard_msg = 1'b0;
        ch_sel = 1'b0; from_master = '0; send_rdy = '0; recv_val = '0;
        recv_msg = '0; clr_err = 1'b0;
        #12;
        chk_reset_state("reset");
        tick();
        reset = 1'b0;
        tick();

        // Fill channel 0 to-device FIFO with the sink stalled.
        for (int i = 1; i <= 4; i++) begin
            serve = 1'b1; from_master = 32'hA5A5_0000 + 32'(i);
            tick();
            if (i == 1) chk("first_word_latency", 64'(send_val), 64'h1);
        end
        chk("tx_space_full", 64'(tx_space), 64'h2);
        chk("head_after_fill", 64'(send_msg[31:0]), 64'hA5A5_0001);
        from_master = 32'hA5A5_0005;
        tick();
        serve = 1'b0;
        chk("ovf_on_fifth", 64'(ovf_err), 64'h1);
        chk("head_unchanged", 64'(send_msg[31:0]), 64'hA5A5_0001);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_cleared", 64'(ovf_err), 64'h0);

        // Device word arrives on channel 1 and is read by the master.
        recv_val = 2'b10; recv_msg = {32'h1234_5678, 32'h0};
        tick();
        recv_val = '0;
        chk("rx_avail_ch1", 64'(rx_avail), 64'h2);
        ch_sel = 1'b1;
        #1;
        chk("to_master_ch1", 64'(to_master), 64'h1234_5678);
        seize = 1'b1;
        tick();
        seize = 1'b0;
        chk("rx_drained", 64'(rx_avail), 64'h0);
        chk("to_master_empty", 64'(to_master), 64'h0);

        // Underflow flags and clear priority.
        ch_sel = 1'b0; seize = 1'b1;
        tick();
        seize = 1'b0;
        chk("udf_ch0", 64'(udf_err), 64'h1);
        chk("to_master_ch0_empty", 64'(to_master), 64'h0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("udf_cleared", 64'(udf_err), 64'h0);
        ch_sel = 1'b1; seize = 1'b1;
        tick();
        chk("udf_ch1", 64'(udf_err), 64'h2);
        ch_sel = 1'b0; clr_err = 1'b1;
        tick();
        seize = 1'b0; clr_err = 1'b0;
        chk("udf_clear_vs_new", 64'(udf_err), 64'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Full FIFO: drain one word while a serve arrives; serve is refused.
        send_rdy = 2'b01; serve = 1'b1; from_master = 32'hA5A5_0006;
        tick();
        serve = 1'b0;
        chk("full_serve_ovf", 64'(ovf_err), 64'h1);
        chk("full_serve_space", 64'(tx_space), 64'h3);
        chk("drain_head_2", 64'(send_msg[31:0]), 64'hA5A5_0002);
        tick();
        chk("drain_head_3", 64'(send_msg[31:0]), 64'hA5A5_0003);
        tick();
        chk("drain_head_4", 64'(send_msg[31:0]), 64'hA5A5_0004);
        tick();
        chk("drained_empty", 64'(send_val), 64'h0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Streaming write/read through the pointer wrap.
        for (int k = 0; k < 12; k++) begin
            serve = 1'b1; from_master = 32'hC0DE_0000 + 32'(k);
            if (k > 0) chk("stream_order", 64'(send_msg[31:0]), 64'(32'hC0DE_0000 + 32'(k - 1)));
            tick();
        end
        serve = 1'b0;
        chk("stream_last", 64'(send_msg[31:0]), 64'hC0DE_000B);
        tick();
        chk("stream_empty", 64'(send_val), 64'h0);
        chk("stream_no_ovf", 64'(ovf_err), 64'h0);
        send_rdy = '0;

        // Control word enqueues nothing.
        ch_sel = 1'b1; hard_msg = 1'b1; serve = 1'b1; from_master = 32'hDEAD_BEEF;
        tick();
        serve = 1'b0; hard_msg = 1'b0;
        chk("hard_no_enq", 64'(send_val), 64'h0);
        chk("hard_no_flag", 64'({ovf_err, udf_err}), 64'h0);

        // Reset mid-stream with two words queued.
        serve = 1'b1; from_master = 32'h0000_0011;
        tick();
        from_master = 32'h0000_0022;
        recv_val = 2'b01; recv_msg = {32'h0, 32'h0000_0033};
        tick();
        serve = 1'b0; recv_val = '0;
        chk("pre_reset_queued", 64'({send_val, rx_avail}), 64'b1001);
        reset = 1'b1;
        #1;
        chk_reset_state("midreset");
        tick();
        reset = 1'b0;
        tick();
        chk_reset_state("postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
